// File: rtl/paillier_decrypt_core_if.sv
// Request/result bundle for the Paillier decryptor: request side in, plaintext/err out.
// master = key bank + result FIFO side, slave = the core.
interface paillier_decrypt_core_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] cipher;
    logic [W-1:0]   n;
    logic [W-1:0]   lambda;
    logic [W-1:0]   mu;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   plaintext;
    logic           err;

    modport master (
        output in_valid, cipher, n, lambda, mu, abort, out_ready,
        input  in_ready, out_valid, plaintext, err
    );

    modport slave (
        input  in_valid, cipher, n, lambda, mu, abort, out_ready,
        output in_ready, out_valid, plaintext, err
    );
endinterface

// File: rtl/paillier_decrypt_core.sv
// Sequential Paillier decryptor m = L(c^lambda mod n^2)*mu mod n; latency 4W^2+3W+2 (err: 2).
// Accepts only when idle; holds the result in DONE until out_ready, abort returns to IDLE.
module paillier_decrypt_core #(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    paillier_decrypt_core_if.slave bus
);
    localparam int CW = $clog2(2*W);
    localparam int BW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_EXP, S_DIV, S_MUL, S_FIN, S_DONE
    } state_t;

    state_t state, state_n;

    logic [2*W-1:0] c_q, nsq_q, acc, mm_r;
    logic [W-1:0]   n_q, lam_q, mu_q, rem, pt_q;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bidx;
    logic           sq_phase, err_q, err_o;

    logic abort_eff, bad, last_cnt, last_bit;
    assign abort_eff = bus.abort && (state != S_IDLE);
    assign bad       = (n_q < W'(2)) || (c_q >= nsq_q) || (c_q == '0) || (mu_q >= n_q);
    assign last_cnt  = (cnt == '0);
    assign last_bit  = (bidx == '0);

    // Shared interleaved modular multiplier: one b bit per cycle, MSB first.
    logic [2*W+1:0] mm_a, mm_m, mm_d, mm_d1, mm_s;
    logic [2*W-1:0] b_src, mm_res, acc_final;
    logic           mm_bit;

    always_comb begin
        mm_a  = '0;
        mm_m  = '0;
        b_src = '0;
        if (state == S_MUL) begin
            mm_a  = (2*W+2)'(acc[W-1:0]);
            mm_m  = (2*W+2)'(n_q);
            b_src = (2*W)'(mu_q);
        end else begin
            mm_a  = (2*W+2)'(acc);
            mm_m  = (2*W+2)'(nsq_q);
            b_src = sq_phase ? acc : c_q;
        end
        mm_bit    = b_src[cnt];
        mm_d      = (2*W+2)'({mm_r, 1'b0});
        mm_d1     = (mm_d >= mm_m) ? (mm_d - mm_m) : mm_d;
        mm_s      = mm_d1 + (mm_bit ? mm_a : '0);
        mm_res    = (2*W)'((mm_s >= mm_m) ? (mm_s - mm_m) : mm_s);
        acc_final = lam_q[bidx] ? mm_res : acc;
    end

    // Restoring divider: dividend shifts out of acc MSB, quotient bits shift into its LSB.
    logic [W:0]     div_sh;
    logic           div_ge;
    logic [W-1:0]   rem_n, q_lo, q_mod;
    logic [2*W-1:0] q_full;

    always_comb begin
        div_sh = {rem, acc[2*W-1]};
        div_ge = (div_sh >= {1'b0, n_q});
        rem_n  = div_ge ? W'(div_sh - {1'b0, n_q}) : div_sh[W-1:0];
        q_full = {acc[2*W-2:0], div_ge};
        q_lo   = q_full[W-1:0];
        q_mod  = (q_lo >= n_q) ? (q_lo - n_q) : q_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_n = S_CHECK;
            S_CHECK: state_n = bad ? S_FIN : S_EXP;
            S_EXP:   if (last_cnt && !sq_phase && last_bit) state_n = S_DIV;
            S_DIV:   if (last_cnt) state_n = S_MUL;
            S_MUL:   if (last_cnt) state_n = S_FIN;
            S_FIN:   state_n = S_DONE;
            S_DONE:  if (bus.out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort_eff) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q      <= '0;
            nsq_q    <= '0;
            n_q      <= '0;
            lam_q    <= '0;
            mu_q     <= '0;
            acc      <= '0;
            mm_r     <= '0;
            rem      <= '0;
            cnt      <= '0;
            bidx     <= '0;
            sq_phase <= 1'b0;
            err_q    <= 1'b0;
            err_o    <= 1'b0;
            pt_q     <= '0;
        end else if (!abort_eff) begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    c_q   <= bus.cipher;
                    n_q   <= bus.n;
                    lam_q <= bus.lambda;
                    mu_q  <= bus.mu;
                    nsq_q <= (2*W)'(bus.n) * (2*W)'(bus.n);
                end
                S_CHECK: begin
                    acc      <= bad ? '0 : (2*W)'(1);
                    err_q    <= bad;
                    mm_r     <= '0;
                    cnt      <= CW'(2*W-1);
                    bidx     <= BW'(W-1);
                    sq_phase <= 1'b1;
                end
                S_EXP: begin
                    if (last_cnt) begin
                        mm_r <= '0;
                        cnt  <= CW'(2*W-1);
                        if (sq_phase) begin
                            acc      <= mm_res;
                            sq_phase <= 1'b0;
                        end else begin
                            // Multiply result is always computed; lambda bit only selects it.
                            sq_phase <= 1'b1;
                            bidx     <= bidx - BW'(1);
                            if (last_bit) begin
                                acc <= acc_final - (2*W)'(1);
                                rem <= '0;
                            end else begin
                                acc <= acc_final;
                            end
                        end
                    end else begin
                        mm_r <= mm_res;
                        cnt  <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    rem <= rem_n;
                    if (last_cnt) begin
                        acc  <= (2*W)'(q_mod);
                        cnt  <= CW'(W-1);
                        mm_r <= '0;
                    end else begin
                        acc <= q_full;
                        cnt <= cnt - CW'(1);
                    end
                end
                S_MUL: begin
                    if (last_cnt) begin
                        acc <= mm_res;
                    end else begin
                        mm_r <= mm_res;
                        cnt  <= cnt - CW'(1);
                    end
                end
                S_FIN: begin
                    pt_q  <= err_q ? '0 : acc[W-1:0];
                    err_o <= err_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.plaintext = pt_q;
    assign bus.err       = err_o;
endmodule

// File: tb/tb_paillier_decrypt_core.sv
// Scoreboard bench for paillier_decrypt_core: expectations queued at accept, checked at result handshake.
module tb_paillier_decrypt_core;
    localparam int W       = 16;
    localparam int LAT     = 4*W*W + 3*W + 2;
    localparam int ERR_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [W:0] sb[$];

    paillier_decrypt_core_if #(.W(W)) bus_if ();

    paillier_decrypt_core #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic on 64-bit integers.
    function automatic logic [W:0] model(input logic [2*W-1:0] c, input logic [W-1:0] nn,
                                         input logic [W-1:0] lam, input logic [W-1:0] m);
        longint unsigned nsq, u, q, cc, nl, ml;
        cc  = 64'(c);
        nl  = 64'(nn);
        ml  = 64'(m);
        nsq = nl * nl;
        if (nl < 64'd2 || cc >= nsq || cc == 64'd0 || ml >= nl)
            return {1'b1, {W{1'b0}}};
        u = 64'd1;
        for (int i = W-1; i >= 0; i--) begin
            u = (u * u) % nsq;
            if (lam[i]) u = (u * cc) % nsq;
        end
        q = ((u - 64'd1) / nl) % nl;
        return {1'b0, W'((q * ml) % nl)};
    endfunction

    task automatic send(input logic [2*W-1:0] c, input logic [W-1:0] nn,
                        input logic [W-1:0] lam, input logic [W-1:0] m);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus_if.in_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_send", bus_if.in_ready, 1);
        bus_if.cipher   = c;
        bus_if.n        = nn;
        bus_if.lambda   = lam;
        bus_if.mu       = m;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        sb.push_back(model(c, nn, lam, m));
        bus_if.in_valid = 1'b0;
    endtask

    task automatic collect(input int exp_lat, input int hold);
        int w;
        logic [W:0] e;
        w = 0;
        while (!bus_if.out_valid && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus_if.out_valid) begin
            chk("result_timeout", 0, 1);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", bus_if.out_valid, 1);
            chk("hold_plaintext", bus_if.plaintext, e[W-1:0]);
            chk("hold_err", bus_if.err, e[W]);
        end
        @(negedge clk);
        chk("plaintext", bus_if.plaintext, e[W-1:0]);
        chk("err", bus_if.err, e[W]);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop_after_hs", bus_if.out_valid, 0);
        chk("in_ready_after_hs", bus_if.in_ready, 1);
        bus_if.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, bus_if.in_ready, 1);
        chk({tag, "_out_valid"}, bus_if.out_valid, 0);
        chk({tag, "_plaintext"}, bus_if.plaintext, 0);
        chk({tag, "_err"}, bus_if.err, 0);
    endtask

    initial begin
        int seen;
        logic [W:0] drop;
        bus_if.in_valid  = 1'b0;
        bus_if.cipher    = '0;
        bus_if.n         = '0;
        bus_if.lambda    = '0;
        bus_if.mu        = '0;
        bus_if.abort     = 1'b0;
        bus_if.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Nominal decryptions with the n=77 key; all share the same latency.
        send(32'd3235, 16'd77, 16'd30, 16'd18); collect(LAT, 0);
        send(32'd1,    16'd77, 16'd30, 16'd18); collect(LAT, 0);
        send(32'd5853, 16'd77, 16'd30, 16'd18); collect(LAT, 0);
        send(32'd3235, 16'd77, 16'd0,  16'd18); collect(LAT, 0);

        // Range-check rejections.
        send(32'd5,    16'd1,  16'd30, 16'd0);  collect(ERR_LAT, 0);
        send(32'd5929, 16'd77, 16'd30, 16'd18); collect(ERR_LAT, 0);
        send(32'd0,    16'd77, 16'd30, 16'd18); collect(ERR_LAT, 0);
        send(32'd3235, 16'd77, 16'd30, 16'd77); collect(ERR_LAT, 0);

        // Busy-time request is ignored; result held under back-pressure.
        send(32'd3235, 16'd77, 16'd30, 16'd18);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus_if.cipher   = 32'd5853;
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        collect(LAT, 50);
        seen = 0;
        repeat (1100) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) seen++;
        end
        chk("extra_result_after_busy_pulse", seen, 0);

        // Abort mid-request.
        send(32'd3235, 16'd77, 16'd30, 16'd18);
        repeat (500) @(posedge clk);
        @(negedge clk);
        bus_if.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", bus_if.in_ready, 1);
        chk("abort_out_valid", bus_if.out_valid, 0);
        @(negedge clk);
        bus_if.abort = 1'b0;
        drop = sb.pop_back();
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        send(32'd3235, 16'd77, 16'd30, 16'd18); collect(LAT, 0);

        // Asynchronous reset in the middle of exponentiation.
        send(32'd3235, 16'd77, 16'd30, 16'd18);
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        drop = sb.pop_back();
        send(32'd5853, 16'd77, 16'd30, 16'd18); collect(LAT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/paillier_decrypt_core.md
Name: paillier_decrypt_core

Overview:
- Parametrised, handshaked Paillier decryption engine computing m = L(c^lambda mod n^2) * mu mod n, where L(u) = (u-1)/n.
- Replaces the fixed-32-bit decryptor with a single sequential datapath: a shared bit-serial modular multiplier, a restoring divider and one control FSM.
- Adds constant-time exponentiation, operand range checking, a synchronous abort and valid/ready flow control on both sides.
- Sits between the key/ciphertext register bank and the plaintext result FIFO.

Parameters:
- W, 16, bit width of n, lambda, mu and plaintext; ciphertext and n^2 are 2W bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  core idle, can accept a request
- cipher  in  2W  ciphertext c
- n  in  W  public modulus
- lambda  in  W  private exponent
- mu  in  W  modular inverse
- abort  in  1  synchronous abort, returns the core to IDLE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- plaintext  out  W  decrypted message
- err  out  1  request rejected; qualified by out_valid

Behaviour:
- Reset: all outputs return to their reset values and the FSM enters IDLE, including mid-operation; in-flight work is discarded.
  - out_valid=0, plaintext=0, err=0, in_ready=1.
- Accept: on a clock edge with in_valid & in_ready, latch cipher, n, lambda and mu, register n_sq = n*n (exact, 2W bits), and go to CHECK. in_ready=1 only in IDLE.
- CHECK (1 cycle): set err if n<2, cipher>=n_sq, cipher==0, or mu>=n.
  - err path: go to DONE with plaintext=0, err=1.
  - otherwise: go to EXP with acc=1, bit index=W-1.
- Modular multiply primitive, modmul(a,b,M) with a<M:
  - Interleaved, MSB-first, one b bit per cycle.
  - Each cycle: r = 2r mod M, then r = r+a mod M if the bit is set. Reduce by conditional subtraction, at most two subtractions per cycle.
  - Intermediate width 2W+2.
  - Takes exactly k cycles for a k-bit b.
- EXP: left-to-right square-and-multiply over all W lambda bits, MSB first, constant time.
  - Per bit: acc=modmul(acc,acc,n_sq) in 2W cycles, then t=modmul(acc,c,n_sq) in 2W cycles.
  - acc=t only if the lambda bit is 1; the multiply is always executed.
  - Total 4W^2 cycles, independent of lambda's value; lambda=0 yields u=1.
- DIV: restoring division q=(u-1)/n, 2W cycles, one quotient bit per cycle. Remainder discarded; q truncated to W bits.
- MUL: plaintext=modmul(q mod n, mu, n), W cycles. q mod n is taken from one extra reduction folded into the last DIV cycle.
- DONE: out_valid=1, holding plaintext and err stable until out_valid & out_ready, then IDLE with out_valid=0.
  - in_ready rises the cycle after the handshake, so no same-cycle re-accept.
- Latency (accept edge to out_valid rising edge):
  - Normal path: 1 (CHECK) + 4W^2 + 2W + W + 1 = 4W^2+3W+2 (W=16: 1074 cycles).
  - err path: 2 cycles.
- abort: takes priority over all transitions. Any state goes to IDLE next cycle, out_valid=0, no result produced. Ignored in IDLE.
- in_valid while busy is ignored; inputs are not re-sampled.
- Output back-pressure: the core stalls in DONE indefinitely; no internal state changes.

Test Plan:
- W=16, n=77, lambda=30, mu=18, cipher=3235 -> plaintext=42, err=0, out_valid exactly 1074 cycles after accept.
- Same key, cipher=1 -> plaintext=0; cipher=5853 -> plaintext=76. Latency is identical for both (constant time).
- n=1 -> err=1, plaintext=0 after 2 cycles. Separately, n=77 with cipher=5929 -> err=1 after 2 cycles.
- Back-pressure and busy: hold out_ready=0 for 50 cycles -> out_valid/plaintext stay stable. Pulse in_valid while busy -> ignored, exactly one result.
- Assert abort at cycle 500 of a request -> in_ready=1 next cycle, no out_valid. A following request (cipher=3235) -> plaintext=42.
- Assert rst mid-EXP -> outputs at reset values immediately; the next request completes correctly.
